// File: rtl/i2si_bist_pkg.sv
// Shared encodings for the I2S-input BIST waveform generator.
package i2si_bist_pkg;

  typedef enum logic [1:0] {
    MODE_SAW   = 2'b00,
    MODE_TRI   = 2'b01,
    MODE_SQR   = 2'b10,
    MODE_CONST = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/i2si_bist_frame_cnt.sv
// Counts serial-clock transitions modulo 2*DW and flags the last transition of each frame.
module i2si_bist_frame_cnt #(
  parameter int unsigned DW = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sck_transition_i,
  output logic boundary_c_o
);

  localparam int unsigned FRAME_LEN = 2 * DW;
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q;
  logic             sck_c;

  // armed_q masks a transition landing on the first clk after reset release
  assign sck_c        = sck_transition_i & armed_q;
  assign boundary_c_o = sck_c && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (sck_c) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= CNT_LAST;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= 1'b1;
    end
  end

endmodule

// File: rtl/i2si_bist_wavegen.sv
// BIST waveform generator for the I2S input path; emits {~S, S} once per frame.
// Triangle mode is built only when I2SI_BIST_TRIANGLE_EN is defined; otherwise mode 01 is sawtooth.
import i2si_bist_pkg::*;

module i2si_bist_wavegen #(
  parameter int unsigned DW    = 16,
  parameter int unsigned CFG_W = 12,
  parameter int unsigned INC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck_transition,
  input  logic              rf_bist_en,
  input  logic [1:0]        rf_bist_mode,
  input  logic [CFG_W-1:0]  rf_bist_start_val,
  input  logic [CFG_W-1:0]  rf_bist_up_limit,
  input  logic [INC_W-1:0]  rf_bist_inc,
  output logic [2*DW-1:0]   i2si_bist_out_data,
  output logic              i2si_bist_out_xfc,
  output logic              i2si_bist_active
);

  localparam int unsigned PAD_W = DW - CFG_W;

  logic          boundary_c;
  logic [DW-1:0] start_c, limit_c, inc_c;

  logic             active_q, active_d;
  logic [DW-1:0]    s_q, s_d;
  logic [INC_W-1:0] sq_cnt_q, sq_cnt_d;
  logic [DW-1:0]    level_q, level_d;
`ifdef I2SI_BIST_TRIANGLE_EN
  dir_e             dir_q, dir_d;
`endif

  i2si_bist_frame_cnt #(
    .DW (DW)
  ) u_frame_cnt (
    .clk              (clk),
    .rst_n            (rst_n),
    .sck_transition_i (sck_transition),
    .boundary_c_o     (boundary_c)
  );

  // Config fields are left-justified; the increment shares the config LSB alignment
  assign start_c = DW'(rf_bist_start_val) << PAD_W;
  assign limit_c = DW'(rf_bist_up_limit) << PAD_W;
  assign inc_c   = DW'(rf_bist_inc) << PAD_W;

  always_comb begin
    active_d = active_q;
    s_d      = s_q;
    sq_cnt_d = sq_cnt_q;
    level_d  = level_q;
`ifdef I2SI_BIST_TRIANGLE_EN
    dir_d    = dir_q;
`endif
    if (boundary_c) begin
      if (!active_q) begin
        if (rf_bist_en) begin
          active_d = 1'b1;
          s_d      = start_c;
          sq_cnt_d = '0;
          level_d  = start_c;
`ifdef I2SI_BIST_TRIANGLE_EN
          dir_d    = DIR_UP;
`endif
        end
      end else if (!rf_bist_en) begin
        active_d = 1'b0;
      end else begin
        case (mode_e'(rf_bist_mode))
`ifdef I2SI_BIST_TRIANGLE_EN
          MODE_SAW: begin
            s_d = ($signed(s_q) >= $signed(limit_c)) ? start_c : s_q + inc_c;
          end
          MODE_TRI: begin
            if (dir_q == DIR_UP) begin
              if ($signed(s_q) >= $signed(limit_c)) begin
                dir_d = DIR_DOWN;
                s_d   = s_q - inc_c;
              end else begin
                s_d   = s_q + inc_c;
              end
            end else begin
              if ($signed(s_q) <= $signed(start_c)) begin
                dir_d = DIR_UP;
                s_d   = s_q + inc_c;
              end else begin
                s_d   = s_q - inc_c;
              end
            end
          end
`else
          MODE_SAW, MODE_TRI: begin
            s_d = ($signed(s_q) >= $signed(limit_c)) ? start_c : s_q + inc_c;
          end
`endif
          MODE_SQR: begin
            if (sq_cnt_q == rf_bist_inc) begin
              level_d  = (level_q == start_c) ? limit_c : start_c;
              sq_cnt_d = '0;
              s_d      = level_d;
            end else begin
              sq_cnt_d = sq_cnt_q + INC_W'(1);
            end
          end
          MODE_CONST: begin
            s_d = start_c;
          end
          default: begin
            s_d = s_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      s_q      <= '0;
      sq_cnt_q <= '0;
      level_q  <= '0;
`ifdef I2SI_BIST_TRIANGLE_EN
      dir_q    <= DIR_UP;
`endif
    end else begin
      active_q <= active_d;
      s_q      <= s_d;
      sq_cnt_q <= sq_cnt_d;
      level_q  <= level_d;
`ifdef I2SI_BIST_TRIANGLE_EN
      dir_q    <= dir_d;
`endif
    end
  end

  assign i2si_bist_out_data = {~s_q, s_q};
  assign i2si_bist_active   = active_q;
  assign i2si_bist_out_xfc  = active_q & boundary_c;

endmodule

// File: tb/tb_i2si_bist_wavegen.sv
// Directed self-checking bench for i2si_bist_wavegen at DW=16, CFG_W=12, INC_W=8.
module tb_i2si_bist_wavegen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sck = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [11:0] sv = '0;
  logic [11:0] ul = '0;
  logic [7:0]  inc = '0;
  logic [31:0] data;
  logic        xfc;
  logic        act;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  i2si_bist_wavegen #(
    .DW    (16),
    .CFG_W (12),
    .INC_W (8)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .sck_transition     (sck),
    .rf_bist_en         (en),
    .rf_bist_mode       (mode),
    .rf_bist_start_val  (sv),
    .rf_bist_up_limit   (ul),
    .rf_bist_inc        (inc),
    .i2si_bist_out_data (data),
    .i2si_bist_out_xfc  (xfc),
    .i2si_bist_active   (act)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // n serial transitions, one clk high then one clk low; counts xfc pulses seen
  task automatic pulses(input int n, output int nx);
    nx = 0;
    repeat (n) begin
      @(negedge clk);
      sck = 1'b1;
      #1;
      if (xfc === 1'b1) nx++;
      @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic do_reset(input logic sck_at_release);
    @(negedge clk);
    rst_n = 1'b0;
    sck   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sck   = sck_at_release;
    @(negedge clk);
    sck   = 1'b0;
  endtask

  function automatic logic [31:0] frm(input logic [15:0] s);
    return {~s, s};
  endfunction

  // Activation boundary then (n-1) full frames, checking S, active and xfc per frame
  task automatic run_seq(input string tag, input int n, input logic [15:0] e [6]);
    int nx;
    pulses(1, nx);
    chk({tag, " act_xfc"}, 32'(nx), 32'd0);
    chk({tag, " act"}, 32'(act), 32'd1);
    chk({tag, " f0"}, data, frm(e[0]));
    for (int i = 1; i < n; i++) begin
      pulses(32, nx);
      chk($sformatf("%s xfc%0d", tag, i), 32'(nx), 32'd1);
      chk($sformatf("%s f%0d", tag, i), data, frm(e[i]));
    end
  endtask

  initial begin
    logic [15:0] e [6];
    int nx;

    #1 rst_n = 1'b0;
    #1;
    chk("rst data", data, 32'hFFFF_0000);
    chk("rst xfc", 32'(xfc), 32'd0);
    chk("rst act", 32'(act), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Disabled generator stays idle across a boundary
    pulses(1, nx);
    chk("idle xfc", 32'(nx), 32'd0);
    chk("idle act", 32'(act), 32'd0);

    // Sawtooth
    do_reset(1'b0);
    en = 1'b1; mode = 2'b00; sv = 12'h010; ul = 12'h020; inc = 8'h08;
    e = '{16'h0100, 16'h0180, 16'h0200, 16'h0100, 16'h0180, 16'h0200};
    run_seq("saw", 6, e);

    // Triangle (sawtooth when the triangle option is not built)
    do_reset(1'b0);
    mode = 2'b01;
`ifdef I2SI_BIST_TRIANGLE_EN
    e = '{16'h0100, 16'h0180, 16'h0200, 16'h0180, 16'h0100, 16'h0180};
`else
    e = '{16'h0100, 16'h0180, 16'h0200, 16'h0100, 16'h0180, 16'h0200};
`endif
    run_seq("tri", 6, e);

    // Square, half-period of 3 frames
    do_reset(1'b0);
    mode = 2'b10; sv = 12'h000; ul = 12'h7FF; inc = 8'h02;
    e = '{16'h0000, 16'h0000, 16'h0000, 16'h7FF0, 16'h7FF0, 16'h7FF0};
    run_seq("sqr", 6, e);

    // Signed wrap past 0x7FFF is negative, so no restart
    do_reset(1'b0);
    mode = 2'b00; sv = 12'h7F0; ul = 12'h7FF; inc = 8'hFF;
    e = '{16'h7F00, 16'h8EF0, 16'h9EE0, 16'hAED0, 16'h0000, 16'h0000};
    run_seq("wrap", 4, e);

    // Constant
    do_reset(1'b0);
    mode = 2'b11; sv = 12'h123;
    e = '{16'h1230, 16'h1230, 16'h1230, 16'h0000, 16'h0000, 16'h0000};
    run_seq("const", 3, e);

    // Mid-frame reset, transition at release ignored, then enable drop
    do_reset(1'b0);
    mode = 2'b00; sv = 12'h010; ul = 12'h020; inc = 8'h08;
    pulses(1, nx);
    pulses(10, nx);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst data", data, 32'hFFFF_0000);
    chk("midrst xfc", 32'(xfc), 32'd0);
    chk("midrst act", 32'(act), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sck   = 1'b1;
    @(negedge clk);
    sck   = 1'b0;
    chk("release ignored act", 32'(act), 32'd0);
    pulses(1, nx);
    chk("reactivate xfc", 32'(nx), 32'd0);
    chk("reactivate act", 32'(act), 32'd1);
    chk("reactivate data", data, frm(16'h0100));
    pulses(32, nx);
    chk("run xfc", 32'(nx), 32'd1);
    chk("run data", data, frm(16'h0180));
    en = 1'b0;
    pulses(32, nx);
    chk("drop xfc", 32'(nx), 32'd1);
    chk("drop act", 32'(act), 32'd0);
    chk("drop data", data, frm(16'h0180));
    pulses(32, nx);
    chk("off xfc", 32'(nx), 32'd0);
    chk("off data", data, frm(16'h0180));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
